// File: rtl/run_monitor_if.sv
// Control/status and CPU observation bundle for run_monitor.
// master = test host / CPU side, slave = the monitor itself.
interface run_monitor_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned CNT_WIDTH  = 16
);
   logic                         start;
   logic                         halt;
   logic [NUM_CH*DATA_WIDTH-1:0] obs_data;
   logic [NUM_CH*DATA_WIDTH-1:0] exp_data;
   logic [NUM_CH-1:0]            ch_mask;
   logic                         cpu_reset;
   logic                         cpu_run;
   logic                         busy;
   logic                         done;
   logic                         pass;
   logic                         timeout;
   logic [NUM_CH-1:0]            fail_mask;
   logic [CNT_WIDTH-1:0]         cycle_count;

   modport master (
      output start, halt, obs_data, exp_data, ch_mask,
      input  cpu_reset, cpu_run, busy, done, pass, timeout, fail_mask, cycle_count
   );

   modport slave (
      input  start, halt, obs_data, exp_data, ch_mask,
      output cpu_reset, cpu_run, busy, done, pass, timeout, fail_mask, cycle_count
   );
endinterface

// File: rtl/run_monitor.sv
// SAP-2 self-test run-and-check controller: resets the CPU, runs it to HLT or budget, compares.
// Optional RUN_MONITOR_SETTLE_EN inserts a 2-cycle SETTLE state between RUN and CHECK.
module run_monitor #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned MAX_CYCLES   = 50,
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input logic          clk,
   input logic          reset,
   run_monitor_if.slave bus
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StRst   = 3'd1;
   localparam logic [2:0] StRun   = 3'd2;
   localparam logic [2:0] StCheck = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;
`ifdef RUN_MONITOR_SETTLE_EN
   localparam logic [2:0]  StSettle   = 3'd5;
   localparam logic [15:0] SettleLast = 16'd1;
`endif

   localparam logic [15:0]          RstLast  = 16'(RESET_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] MaxCount = CNT_WIDTH'(MAX_CYCLES);

   logic [2:0]           state_q, state_d;
   logic [15:0]          phase_q, phase_d;
   logic                 cpu_reset_q, cpu_reset_d;
   logic                 cpu_run_q, cpu_run_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic                 timeout_q, timeout_d;
   logic [NUM_CH-1:0]    fail_mask_q, fail_mask_d;
   logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
   logic [CNT_WIDTH-1:0] count_inc;
   logic [NUM_CH-1:0]    mismatch;

   always_comb begin
      mismatch = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         mismatch[i] = bus.ch_mask[i] &
                       (bus.obs_data[i*DATA_WIDTH +: DATA_WIDTH] !=
                        bus.exp_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // Saturating increment; the RUN exit below keeps it from ever passing MAX_CYCLES.
   assign count_inc = (cycle_count_q >= MaxCount) ? MaxCount : cycle_count_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      cpu_reset_d   = cpu_reset_q;
      cpu_run_d     = cpu_run_q;
      busy_d        = busy_q;
      done_d        = done_q;
      pass_d        = pass_q;
      timeout_d     = timeout_q;
      fail_mask_d   = fail_mask_q;
      cycle_count_d = cycle_count_q;

      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d       = StRst;
               phase_d       = '0;
               cpu_reset_d   = 1'b1;
               cpu_run_d     = 1'b0;
               busy_d        = 1'b1;
               done_d        = 1'b0;
               pass_d        = 1'b0;
               timeout_d     = 1'b0;
               fail_mask_d   = '0;
               cycle_count_d = '0;
            end
         end
         StRst: begin
            if (phase_q == RstLast) begin
               state_d     = StRun;
               phase_d     = '0;
               cpu_reset_d = 1'b0;
               cpu_run_d   = 1'b1;
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
         StRun: begin
            // halt takes priority over a budget expiring in the same cycle
            if (bus.halt) begin
               cpu_run_d = 1'b0;
`ifdef RUN_MONITOR_SETTLE_EN
               state_d   = StSettle;
               phase_d   = '0;
`else
               state_d   = StCheck;
`endif
            end else begin
               cycle_count_d = count_inc;
               if (count_inc >= MaxCount) begin
                  state_d     = StDone;
                  cpu_run_d   = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  timeout_d   = 1'b1;
                  pass_d      = 1'b0;
                  fail_mask_d = '0;
               end
            end
         end
`ifdef RUN_MONITOR_SETTLE_EN
         StSettle: begin
            if (phase_q == SettleLast) begin
               state_d = StCheck;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
`endif
         StCheck: begin
            state_d     = StDone;
            fail_mask_d = mismatch;
            pass_d      = (mismatch == '0);
            busy_d      = 1'b0;
            done_d      = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         phase_q       <= '0;
         cpu_reset_q   <= 1'b1;
         cpu_run_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         timeout_q     <= 1'b0;
         fail_mask_q   <= '0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         cpu_reset_q   <= cpu_reset_d;
         cpu_run_q     <= cpu_run_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         timeout_q     <= timeout_d;
         fail_mask_q   <= fail_mask_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign bus.cpu_reset   = cpu_reset_q;
   assign bus.cpu_run     = cpu_run_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.timeout     = timeout_q;
   assign bus.fail_mask   = fail_mask_q;
   assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: vector table, hand-written corner sequences and
// randomized runs against a cycle-level reference model.
module tb_run_monitor;
   localparam int DW  = 8;
   localparam int NCH = 4;
   localparam int MAX = 50;
   localparam int R   = 2;
   localparam int CW  = 16;
`ifdef RUN_MONITOR_SETTLE_EN
   localparam int SETTLE = 2;
`else
   localparam int SETTLE = 0;
`endif
   localparam int NEVER = 100000;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   run_monitor_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(CW)) bus ();

   run_monitor #(
      .DATA_WIDTH  (DW),
      .NUM_CH      (NCH),
      .MAX_CYCLES  (MAX),
      .RESET_CYCLES(R),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int         h;       // non-halt RUN cycles before halt (>= MAX means never halts)
      logic [31:0] obs;
      logic [31:0] expv;
      logic [3:0] mask;
      logic       e_pass;
      logic       e_to;
      logic [3:0] e_fm;
      int         e_cnt;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] ctrl_now();
      return {28'd0, bus.cpu_reset, bus.cpu_run, bus.busy, bus.done};
   endfunction

   function automatic logic [31:0] results_now();
      return {11'd0, bus.pass, bus.timeout, bus.fail_mask, bus.cycle_count};
   endfunction

   // Reference model: outcome of a run from the rules (halt count, budget, per-channel compare).
   function automatic vec_t model(input int h, input logic [31:0] obs, input logic [31:0] expv,
                                  input logic [3:0] mask);
      vec_t v;
      v.h = h; v.obs = obs; v.expv = expv; v.mask = mask;
      v.e_to = (h >= MAX);
      v.e_cnt = v.e_to ? MAX : h;
      v.e_fm = 4'd0;
      if (!v.e_to) begin
         for (int c = 0; c < NCH; c++) begin
            if (mask[c] && (obs[c*8 +: 8] != expv[c*8 +: 8])) v.e_fm[c] = 1'b1;
         end
      end
      v.e_pass = !v.e_to && (v.e_fm == 4'd0);
      return v;
   endfunction

   // One complete run; checks control outputs at every edge and results at done.
   task automatic do_run(input vec_t v, input int glitch_edge, input string name);
      bit to;
      int run_exit, done_edge;
      logic [31:0] exp_ctrl;
      to        = (v.h >= MAX);
      run_exit  = to ? R + MAX : R + v.h + 1;
      done_edge = to ? R + MAX : R + v.h + 2 + SETTLE;
      bus.halt     = 1'b0;
      bus.obs_data = v.obs;
      bus.exp_data = v.expv;
      bus.ch_mask  = v.mask;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check({name, "/start_ctrl"}, ctrl_now(), 32'b1010);
      check({name, "/start_clear"}, results_now(), 32'd0);
      for (int e = 1; e <= done_edge; e++) begin
         @(negedge clk);
         bus.halt  = !to && (e >= R + v.h + 1);
         bus.start = (e == glitch_edge);
         @(posedge clk);
         #1;
         exp_ctrl = {28'd0, 1'(e < R), 1'(e >= R && e < run_exit), 1'(e < done_edge),
                     1'(e >= done_edge)};
         check($sformatf("%s/ctrl@%0d", name, e), ctrl_now(), exp_ctrl);
      end
      @(negedge clk);
      bus.start = 1'b0;
      check({name, "/pass"}, 32'(bus.pass), 32'(v.e_pass));
      check({name, "/timeout"}, 32'(bus.timeout), 32'(v.e_to));
      check({name, "/fail_mask"}, 32'(bus.fail_mask), 32'(v.e_fm));
      check({name, "/cycle_count"}, 32'(bus.cycle_count), 32'(v.e_cnt));
      check({name, "/held_ctrl"}, ctrl_now(), 32'b0001);
   endtask

   vec_t tbl[7];

   initial begin
      logic [31:0] ob, ex;
      vec_t v;
      //            h    obs           exp           mask     pass  to    fm       cnt
      tbl[0] = '{12,  32'h000000AB, 32'h000000AB, 4'b0001, 1'b1, 1'b0, 4'b0000, 12};
      tbl[1] = '{5,   32'h005511AA, 32'h005522AB, 4'b0101, 1'b0, 1'b0, 4'b0001, 5};
      tbl[2] = '{NEVER, 32'h00000000, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b1, 4'b0000, 50};
      tbl[3] = '{49,  32'h12345678, 32'h12345678, 4'b1111, 1'b1, 1'b0, 4'b0000, 49};
      tbl[4] = '{0,   32'hDEADBEEF, 32'h00000000, 4'b0000, 1'b1, 1'b0, 4'b0000, 0};
      tbl[5] = '{3,   32'h01020304, 32'h11020314, 4'b1111, 1'b0, 1'b0, 4'b1001, 3};
      tbl[6] = '{50,  32'hAAAAAAAA, 32'hAAAAAAAA, 4'b1111, 1'b0, 1'b1, 4'b0000, 50};

      reset = 1'b1;
      bus.start = 1'b0; bus.halt = 1'b0;
      bus.obs_data = '0; bus.exp_data = '0; bus.ch_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", ctrl_now(), 32'b1000);
      check("reset_results", results_now(), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_ctrl", ctrl_now(), 32'b1000);

      for (int i = 0; i < 7; i++) do_run(tbl[i], -1, $sformatf("vec%0d", i));

      // start during RST and during RUN must be ignored
      do_run(model(20, 32'h0000_00AB, 32'h0000_00AB, 4'b0001), 1, "start_in_rst");
      do_run(model(20, 32'h0000_0012, 32'h0000_0013, 4'b0001), R + 6, "start_in_run");

      // reset during RUN aborts straight to reset values
      bus.halt = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (R + 4) @(negedge clk);
      check("pre_abort_run", ctrl_now(), 32'b0110);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_ctrl", ctrl_now(), 32'b1000);
      check("abort_results", results_now(), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort_idle", ctrl_now(), 32'b1000);

      for (int i = 0; i < 20; i++) begin
         ex = $urandom;
         ob = ex;
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 1) == 1) ob[c*8 +: 8] = ex[c*8 +: 8] ^ 8'($urandom_range(1, 255));
         end
         v = model(int'($urandom_range(0, 55)), ob, ex, 4'($urandom));
         do_run(v, -1, $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
